mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving four cores exclusive, one-at-a-time access to a
// shared single-port data memory through an IDLE -> ACCESS -> RELEASE cycle.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int NUM_CORES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [1:0]                  owner,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic                        mem_write,
    output logic                        mem_read,
    input  logic [DATA_W-1:0]           mem_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state_r;
    logic [1:0]          ptr_r;
    logic                we_r;
    logic [1:0]          winner_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_wdata_s;

    // First requesting core found when scanning upward from the pointer, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [NUM_CORES-1:0] r,
                                           input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Winner selection and its operand mux.
    always_comb begin
        winner_s    = rr_pick(req, ptr_r);
        win_addr_s  = addr[winner_s*ADDR_W +: ADDR_W];
        win_wdata_s = wdata[winner_s*DATA_W +: DATA_W];
    end

    // Arbitration FSM with all outputs registered; strobes are cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= 2'd0;
            we_r        <= 1'b0;
            owner       <= 2'd0;
            ack         <= {NUM_CORES{1'b0}};
            busy        <= 1'b0;
            rdata       <= {DATA_W{1'b0}};
            mem_addr    <= {ADDR_W{1'b0}};
            mem_data_in <= {DATA_W{1'b0}};
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack <= {NUM_CORES{1'b0}};
                    if (req != {NUM_CORES{1'b0}}) begin
                        state_r     <= ACCESS;
                        owner       <= winner_s;
                        ptr_r       <= winner_s + 2'd1;
                        mem_addr    <= win_addr_s;
                        mem_data_in <= win_wdata_s;
                        we_r        <= we[winner_s];
                        mem_write   <= we[winner_s];
                        mem_read    <= ~we[winner_s];
                        busy        <= 1'b1;
                    end else begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ACCESS: begin
                    state_r   <= RELEASE;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    ack       <= {{(NUM_CORES-1){1'b0}}, 1'b1} << owner;
                    if (!we_r) begin
                        rdata <= mem_data_out;
                    end else begin
                        rdata <= rdata;
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                    ack     <= {NUM_CORES{1'b0}};
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    ack       <= {NUM_CORES{1'b0}};
                    busy      <= 1'b0;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized core
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      req, we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [3:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      owner;
    logic            busy;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_in;
    logic            mem_write, mem_read;
    logic [DW-1:0]   mem_data_out;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state (phase 0 = waiting, 1 = memory cycle, 2 = acknowledge cycle)
    int         m_phase, m_ptr, m_owner;
    logic [3:0] m_ack;
    logic       m_busy, m_wr, m_rd, m_we;
    logic [DW-1:0] m_addr, m_din, m_rdata;
    int         wait_cnt [4];
    logic [3:0] pend;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CORES(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .owner(owner), .busy(busy), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_read(mem_read),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_data_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_owner = 0; m_ack = 4'd0;
        m_busy = 1'b0; m_wr = 1'b0; m_rd = 1'b0; m_we = 1'b0;
        m_addr = 16'd0; m_din = 16'd0; m_rdata = 16'd0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    endtask

    task automatic model_edge();
        int w;
        int worst;
        if (m_phase == 0) begin
            if (req != 4'd0) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_owner = w;
                m_ptr   = (w + 1) % 4;
                m_addr  = addr[w*AW +: AW];
                m_din   = wdata[w*DW +: DW];
                m_we    = we[w];
                m_wr    = m_we;
                m_rd    = !m_we;
                m_busy  = 1'b1;
                m_phase = 1;
                worst = 0;
                for (int j = 0; j < 4; j++) begin
                    if (j == w || !req[j]) wait_cnt[j] = 0;
                    else wait_cnt[j]++;
                    if (wait_cnt[j] > worst) worst = wait_cnt[j];
                end
                chk("fair_wait", (worst <= 3), 1'b1);
            end
        end else if (m_phase == 1) begin
            if (m_we) ref_mem[m_addr] = m_din;
            else      m_rdata = ref_mem[m_addr];
            m_wr = 1'b0; m_rd = 1'b0;
            m_ack = 4'b0001 << m_owner;
            m_phase = 2;
        end else begin
            m_ack = 4'd0; m_busy = 1'b0; m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] mo;
        mo = m_owner[1:0];
        chk("ctl", {ack, owner, busy, mem_write, mem_read}, {m_ack, mo, m_busy, m_wr, m_rd});
        chk("rdata", rdata, m_rdata);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data_in", mem_data_in, m_din);
        chk("excl", {$onehot0(ack), !(mem_write && mem_read)}, 2'b11);
    endtask

    task automatic agents();
        for (int i = 0; i < 4; i++) begin
            if (m_ack[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
                pend[i] = 1'b1;
                we[i] = 1'($urandom_range(0, 1));
                addr[i*AW +: AW]  = 16'($urandom_range(0, 15));
                wdata[i*DW +: DW] = 16'($urandom);
            end
            req[i] = pend[i];
        end
    endtask

    task automatic tick(input bit drive_agents);
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_outputs();
        if (drive_agents) agents();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) tick(1'b0);
    endtask

    function automatic int ack_idx(input logic [3:0] a);
        int r = -1;
        for (int i = 0; i < 4; i++) if (a[i]) r = i;
        return r;
    endfunction

    initial begin
        int n_acks, last_cyc, cyc, others;
        bit seen;
        int order [5];
        for (int i = 0; i < 65536; i++) begin mem[i] = 16'd0; ref_mem[i] = 16'd0; end
        req = 4'd0; we = 4'd0; addr = '0; wdata = '0; pend = 4'd0;
        #2;
        do_reset();

        // Idle with no requests
        reset_n = 1'b1;
        repeat (20) tick(1'b0);

        // Single read by core 2
        mem[998] = 16'd3; ref_mem[998] = 16'd3;
        addr[2*AW +: AW] = 16'd998; we = 4'b0000; req = 4'b0100;
        tick(1'b0);
        chk("rd_strobe", {mem_read, mem_write, mem_addr}, {1'b1, 1'b0, 16'd998});
        tick(1'b0);
        chk("rd_ack", ack, 4'b0100);
        chk("rd_data", rdata, 16'd3);
        req = 4'd0;
        repeat (2) tick(1'b0);

        // Write 0x00AB to 999 by core 1, then read it back
        addr[1*AW +: AW] = 16'd999; wdata[1*DW +: DW] = 16'h00AB; we = 4'b0010; req = 4'b0010;
        n_acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick(1'b0);
            if (mem_write) n_acks++;
        end
        chk("wr_once", n_acks, 1);
        we = 4'b0000;
        repeat (3) tick(1'b0);
        chk("wr_rd_data", rdata, 16'h00AB);
        req = 4'd0;
        tick(1'b0);

        // Contention: all cores request from reset
        req = 4'b1111; we = 4'd0;
        do_reset();
        reset_n = 1'b1;
        n_acks = 0; last_cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            tick(1'b0);
            if (ack != 4'd0) begin
                if (n_acks > 0) chk("cont_gap", c - last_cyc, 3);
                if (n_acks < 5) order[n_acks] = ack_idx(ack);
                n_acks++;
                last_cyc = c;
            end
        end
        chk("cont_cnt", n_acks, 5);
        for (int i = 0; i < 5; i++) chk("cont_order", order[i], i % 4);

        // Fairness: core 0 continuous, core 3 requests once
        req = 4'b0001; we = 4'd0;
        repeat (4) tick(1'b0);
        req = 4'b1001; others = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick(1'b0);
            if (ack[3]) begin seen = 1; req[3] = 1'b0; end
            else if (ack != 4'd0) others++;
        end
        chk("fair_seen", seen, 1'b1);
        chk("fair_grants", (others <= 2), 1'b1);
        req = 4'd0;
        repeat (3) tick(1'b0);

        // Reset during the memory cycle of a write
        mem[5] = 16'h5555; ref_mem[5] = 16'h5555;
        addr[0 +: AW] = 16'd5; wdata[0 +: DW] = 16'h1234; we = 4'b0001; req = 4'b0001;
        tick(1'b0);
        chk("mw_strobe", mem_write, 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        req = 4'd0; we = 4'd0;
        @(posedge clk); #1;
        chk("mw_mem", mem[5], 16'h5555);
        check_outputs();
        reset_n = 1'b1;
        tick(1'b0);

        // Randomized traffic from all cores
        pend = 4'd0;
        for (int c = 0; c < 600; c++) tick(1'b1);
        req = 4'd0; pend = 4'd0;
        repeat (4) tick(1'b0);
        for (int a = 0; a < 16; a++) chk("mem_final", mem[a], ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
